pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised data-hazard unit for the five-stage MIPS pipeline, replacing the fixed stall-only conflict checker. Keeps a scoreboard of in-flight register writes for a configurable number of post-decode stages and, for the instruction in ID, produces a forwarding source per operand or a stall request. Generalises hazard handling with optional forwarding, late-result (load) latency, a flush input and saturating stall/forward performance counters. Sits beside ID; `stall` drives PC/IF-ID hold and the ID-to-EX bubble; `fwd_*_sel` drive operand muxes at the EX input.

## Interface
Parameters:
- STAGES, 2, tracked stages after ID (1 = EX, 2 = MEM, ...); WB excluded, as the register file writes through
- RA_W, 5, register-number width
- FWD_EN, 1, 1 = forwarding enabled, 0 = stall on every tracked match
- LOAD_LAT, 2, first stage index whose output holds a load result (1..STAGES)
- CNT_W, 32, performance counter width

Ports (SEL_W = $clog2(STAGES+1)):
- clk  in  1  pipeline clock, rising edge
- CLR_n  in  1  reset, asynchronous, active-low
- halt  in  1  freeze: no scoreboard or counter update
- flush  in  1  discard all in-flight entries and the ID instruction
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RA_W  source register numbers
- id_rs_used, id_rt_used  in  1  source actually read
- id_wr_en  in  1  instruction writes a register
- id_wr_num  in  RA_W  destination register
- id_is_load  in  1  result available only at stage LOAD_LAT
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- fwd_rs_sel, fwd_rt_sel  out  SEL_W  0 = register file, k = output of stage k
- stall_cnt  out  CNT_W  stall cycles counted
- fwd_cnt  out  CNT_W  issued instructions that used a forward

## Operation
- Scoreboard entry k (1..STAGES): valid, num (RA_W), late (1). Entry k result is available iff valid and (!late or k >= LOAD_LAT).
- Per source r with used=1 and r != 0: find smallest k with valid[k] and num[k]==r (youngest writer wins).
  - No match: sel = 0, no hazard.
  - FWD_EN=1: available -> sel = k; not available -> hazard, sel = 0.
  - FWD_EN=0: any match -> hazard, sel = 0.
- Unused source or r == 0: sel = 0, never a hazard.
- stall = id_valid & !flush & (rs hazard | rt hazard). Combinational; stall forces both sels to 0.
- Update on rising edge, priority: reset > halt > flush > normal.
  - halt: all state and counters hold.
  - flush: all valid cleared; counters unchanged.
  - normal: entry k+1 <= entry k for k < STAGES; entry STAGES retires. Entry 1 <= {1, id_wr_num, id_is_load} if id_valid & !stall & id_wr_en & id_wr_num != 0, else bubble (valid=0).
- stall_cnt += 1 on normal cycles with stall=1; fwd_cnt += 1 on normal cycles with id_valid & !stall & (either sel != 0). Both saturate at all-ones.

## Timing
- Reset (CLR_n low, asynchronous): all valid = 0, counters = 0; hence stall = 0, sels = 0, stall_cnt = fwd_cnt = 0 while held.
- Hazard outputs valid same cycle as ID inputs (zero latency); scoreboard reflects issue one edge later.
- FWD_EN=1: dependent ALU op back-to-back -> 0 stalls (sel = 1); load-use with LOAD_LAT=2 -> 1 stall then sel = 2; LOAD_LAT=L -> L-1 stalls.
- FWD_EN=0: back-to-back dependence -> STAGES stall cycles; dependence at distance d -> max(0, STAGES+1-d) stalls.
- Stall does not stop older entries shifting; the bubble advances, so stalls always terminate.
- Simultaneous flush and stall: stall output forced 0, scoreboard cleared. Simultaneous halt and flush: halt wins, flush lost.
- Reset asserted mid-stall drops stall immediately; no partial state survives.

## Test plan
- Reset: CLR_n low mid-operation with 2 valid entries -> stall=0, sels=0, counters=0 immediately; after release first instruction issues with sel=0.
- FWD_EN=1: add $3,$1,$2 then sub $4,$3,$5 -> no stall, fwd_rs_sel=1; next cycle or $6,$3,$0 -> fwd_rs_sel=2; fwd_cnt=2.
- FWD_EN=1, LOAD_LAT=2: lw $8 then add $9,$8,$8 -> stall=1 one cycle, then fwd_rs_sel=fwd_rt_sel=2; stall_cnt=1.
- FWD_EN=0, STAGES=2: back-to-back dependence -> stall 2 cycles, sels 0; dependence at distance 3 -> no stall; writes to $0 never stall.
- Two writers of $7 in stages 1 and 2, ID reads $7 -> fwd_rs_sel=1 (youngest).
- flush during a load-use stall -> stall=0 that cycle, next cycle all entries invalid; halt for 5 cycles during stall -> counters and scoreboard frozen; CNT_W=4 with 20 stalls -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Data-hazard unit for the ID stage: tracks in-flight register writes per post-decode stage and
// picks a forwarding source per operand, or requests a stall when the value is not ready yet.
module pipe_hazard_unit #(
    parameter int unsigned STAGES   = 2,
    parameter int unsigned RA_W     = 5,
    parameter int unsigned FWD_EN   = 1,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 32,
    localparam int unsigned SEL_W   = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             CLR_n,
    input  logic             halt,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_wr_en,
    input  logic [RA_W-1:0]  id_wr_num,
    input  logic             id_is_load,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_rs_sel,
    output logic [SEL_W-1:0] fwd_rt_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    logic [STAGES:1] valid_q;
    logic [STAGES:1] late_q;
    logic [RA_W-1:0] num_q [1:STAGES];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_q;

    logic [RA_W-1:0]  src [2];
    logic [1:0]       used;
    logic [1:0]       hazard;
    logic [SEL_W-1:0] raw_sel [2];
    logic             found;
    logic             ready;
    logic [SEL_W-1:0] hit_k;
    logic             issue;
    logic             fwd_used;

    always_comb begin
        src[0]     = id_rs;
        src[1]     = id_rt;
        used       = {id_rt_used, id_rs_used};
        hazard     = '0;
        raw_sel[0] = '0;
        raw_sel[1] = '0;
        found      = 1'b0;
        ready      = 1'b0;
        hit_k      = '0;
        for (int s = 0; s < 2; s++) begin
            found = 1'b0;
            ready = 1'b0;
            hit_k = '0;
            // Scan oldest to youngest so the youngest matching writer is the one kept.
            for (int k = int'(STAGES); k >= 1; k--) begin
                if (valid_q[k] && num_q[k] == src[s]) begin
                    found = 1'b1;
                    hit_k = SEL_W'(k);
                    ready = !late_q[k] || (k >= int'(LOAD_LAT));
                end
            end
            if (used[s] && src[s] != '0 && found) begin
                if (FWD_EN != 0 && ready) begin
                    raw_sel[s] = hit_k;
                end else begin
                    hazard[s] = 1'b1;
                end
            end
        end
    end

    assign stall      = id_valid && !flush && (hazard != '0);
    assign fwd_rs_sel = stall ? '0 : raw_sel[0];
    assign fwd_rt_sel = stall ? '0 : raw_sel[1];
    assign issue      = id_valid && !stall && id_wr_en && (id_wr_num != '0);
    assign fwd_used   = id_valid && !stall && (fwd_rs_sel != '0 || fwd_rt_sel != '0);

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            valid_q     <= '0;
            late_q      <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
            for (int k = 1; k <= int'(STAGES); k++) begin
                num_q[k] <= '0;
            end
        end else if (!halt) begin
            if (flush) begin
                valid_q <= '0;
            end else begin
                // Older entries keep advancing during a stall; the slot behind them is a bubble.
                for (int k = int'(STAGES); k >= 2; k--) begin
                    valid_q[k] <= valid_q[k-1];
                    late_q[k]  <= late_q[k-1];
                    num_q[k]   <= num_q[k-1];
                end
                valid_q[1] <= issue;
                late_q[1]  <= id_is_load;
                num_q[1]   <= id_wr_num;
                if (stall && stall_cnt_q != '1) begin
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                end
                if (fwd_used && fwd_cnt_q != '1) begin
                    fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: three configurations share one stimulus stream and are
// checked every cycle against an age-indexed model of in-flight register writes.
module tb_pipe_hazard_unit;

    localparam int ST [3] = '{2, 2, 4};
    localparam int FW [3] = '{1, 0, 1};
    localparam int LL [3] = '{2, 2, 3};
    localparam int CW [3] = '{32, 4, 8};

    logic clk = 1'b0;
    logic clr_n, halt, flush, id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load;
    logic [4:0] id_rs, id_rt, id_wr_num;

    logic        st0, st1, st2;
    logic [1:0]  rs0, rt0, rs1, rt1;
    logic [2:0]  rs2, rt2;
    logic [31:0] sc0, fc0;
    logic [3:0]  sc1, fc1;
    logic [7:0]  sc2, fc2;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.STAGES(2), .RA_W(5), .FWD_EN(1), .LOAD_LAT(2), .CNT_W(32)) dut0 (
        .clk(clk), .CLR_n(clr_n), .halt(halt), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_wr_num(id_wr_num), .id_is_load(id_is_load),
        .stall(st0), .fwd_rs_sel(rs0), .fwd_rt_sel(rt0), .stall_cnt(sc0), .fwd_cnt(fc0));

    pipe_hazard_unit #(.STAGES(2), .RA_W(5), .FWD_EN(0), .LOAD_LAT(2), .CNT_W(4)) dut1 (
        .clk(clk), .CLR_n(clr_n), .halt(halt), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_wr_num(id_wr_num), .id_is_load(id_is_load),
        .stall(st1), .fwd_rs_sel(rs1), .fwd_rt_sel(rt1), .stall_cnt(sc1), .fwd_cnt(fc1));

    pipe_hazard_unit #(.STAGES(4), .RA_W(5), .FWD_EN(1), .LOAD_LAT(3), .CNT_W(8)) dut2 (
        .clk(clk), .CLR_n(clr_n), .halt(halt), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_wr_num(id_wr_num), .id_is_load(id_is_load),
        .stall(st2), .fwd_rs_sel(rs2), .fwd_rt_sel(rt2), .stall_cnt(sc2), .fwd_cnt(fc2));

    logic [2:0]  a_st;
    logic [2:0]  a_rs [3];
    logic [2:0]  a_rt [3];
    logic [63:0] a_sc [3];
    logic [63:0] a_fc [3];

    assign a_st    = {st2, st1, st0};
    assign a_rs[0] = 3'(rs0);
    assign a_rs[1] = 3'(rs1);
    assign a_rs[2] = rs2;
    assign a_rt[0] = 3'(rt0);
    assign a_rt[1] = 3'(rt1);
    assign a_rt[2] = rt2;
    assign a_sc[0] = 64'(sc0);
    assign a_sc[1] = 64'(sc1);
    assign a_sc[2] = 64'(sc2);
    assign a_fc[0] = 64'(fc0);
    assign a_fc[1] = 64'(fc1);
    assign a_fc[2] = 64'(fc2);

    typedef struct packed {
        logic [31:0]      cyc;
        logic [2:0]       st;
        logic [2:0][2:0]  rs;
        logic [2:0][2:0]  rt;
        logic [2:0][63:0] sc;
        logic [2:0][63:0] fc;
    } exp_t;

    exp_t sbq [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    // Model: in-flight writes indexed by age in cycles since leaving ID.
    bit     mv [3][1:4];
    bit     ml [3][1:4];
    int     mn [3][1:4];
    longint msc [3];
    longint mfc [3];
    bit     e_st [3];
    int     e_rs [3];
    int     e_rt [3];

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int a = 1; a <= 4; a++) begin
                mv[c][a] = 0;
                ml[c][a] = 0;
                mn[c][a] = 0;
            end
            msc[c] = 0;
            mfc[c] = 0;
        end
    endfunction

    function automatic void lookup(input int c, input int r, input bit u,
                                   output int sel, output bit haz);
        sel = 0;
        haz = 0;
        if (!u || r == 0) return;
        for (int age = 1; age <= ST[c]; age++) begin
            if (mv[c][age] && mn[c][age] == r) begin
                if (FW[c] != 0 && (!ml[c][age] || age >= LL[c])) sel = age;
                else haz = 1;
                return;
            end
        end
    endfunction

    function automatic void model_expect();
        int  s1, s2;
        bit  h1, h2, st;
        for (int c = 0; c < 3; c++) begin
            lookup(c, int'(id_rs), id_rs_used, s1, h1);
            lookup(c, int'(id_rt), id_rt_used, s2, h2);
            st      = id_valid && !flush && (h1 || h2);
            e_st[c] = st;
            e_rs[c] = st ? 0 : s1;
            e_rt[c] = st ? 0 : s2;
        end
    endfunction

    function automatic void model_edge();
        longint mx;
        if (halt) return;
        for (int c = 0; c < 3; c++) begin
            if (flush) begin
                for (int a = 1; a <= 4; a++) mv[c][a] = 0;
            end else begin
                mx = (longint'(1) << CW[c]) - 1;
                if (e_st[c] && msc[c] < mx) msc[c]++;
                if (id_valid && !e_st[c] && (e_rs[c] != 0 || e_rt[c] != 0) && mfc[c] < mx)
                    mfc[c]++;
                for (int a = ST[c]; a >= 2; a--) begin
                    mv[c][a] = mv[c][a-1];
                    ml[c][a] = ml[c][a-1];
                    mn[c][a] = mn[c][a-1];
                end
                mv[c][1] = id_valid && !e_st[c] && id_wr_en && id_wr_num != 0;
                ml[c][1] = id_is_load;
                mn[c][1] = int'(id_wr_num);
            end
        end
    endfunction

    task automatic cyc(input bit v, input int rs, input int rt, input bit ru, input bit tu,
                       input bit we, input int wn, input bit ld,
                       input bit h = 0, input bit f = 0, input bit rn = 1);
        exp_t e;
        @(posedge clk);
        if (clr_n) model_edge();
        #1;
        clr_n      = rn;
        id_valid   = v;
        id_rs      = 5'(rs);
        id_rt      = 5'(rt);
        id_rs_used = ru;
        id_rt_used = tu;
        id_wr_en   = we;
        id_wr_num  = 5'(wn);
        id_is_load = ld;
        halt       = h;
        flush      = f;
        if (!rn) model_reset();
        model_expect();
        cyc_n++;
        e.cyc = 32'(cyc_n);
        for (int c = 0; c < 3; c++) begin
            e.st[c] = e_st[c];
            e.rs[c] = 3'(e_rs[c]);
            e.rt[c] = 3'(e_rt[c]);
            e.sc[c] = 64'(msc[c]);
            e.fc[c] = 64'(mfc[c]);
        end
        sbq.push_back(e);
    endtask

    task automatic iss(input int rs, input int rt, input int wn, input bit ld);
        cyc(1, rs, rt, 1, 1, 1, wn, ld);
    endtask

    task automatic bub();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int c, input int cy,
                       input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0d want %0d", nm, c, cy, got, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                for (int c = 0; c < 3; c++) begin
                    chk("stall", c, int'(e.cyc), 64'(a_st[c]), 64'(e.st[c]));
                    chk("fwd_rs_sel", c, int'(e.cyc), 64'(a_rs[c]), 64'(e.rs[c]));
                    chk("fwd_rt_sel", c, int'(e.cyc), 64'(a_rt[c]), 64'(e.rt[c]));
                    chk("stall_cnt", c, int'(e.cyc), a_sc[c], e.sc[c]);
                    chk("fwd_cnt", c, int'(e.cyc), a_fc[c], e.fc[c]);
                end
            end
        end
    end

    initial begin
        clr_n = 0; halt = 0; flush = 0; id_valid = 0; id_rs = 0; id_rt = 0;
        id_rs_used = 0; id_rt_used = 0; id_wr_en = 0; id_wr_num = 0; id_is_load = 0;
        model_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // add $3,$1,$2 ; sub $4,$3,$5 ; or $6,$3,$0
        iss(1, 2, 3, 0);
        iss(3, 5, 4, 0);
        iss(3, 0, 6, 0);
        repeat (3) bub();
        // lw $8 ; add $9,$8,$8 held in ID while stalled
        cyc(1, 1, 0, 1, 0, 1, 8, 1);
        repeat (3) iss(8, 8, 9, 0);
        repeat (4) bub();
        // two writers of $7, youngest wins
        iss(0, 0, 7, 0);
        iss(0, 0, 7, 0);
        iss(7, 0, 10, 0);
        // writes to $0 never create hazards
        iss(1, 1, 0, 0);
        iss(0, 0, 11, 0);
        // dependence at distance 3
        iss(1, 1, 12, 0);
        bub();
        bub();
        iss(12, 12, 13, 0);
        repeat (4) bub();
        // flush during load-use stall
        cyc(1, 1, 0, 1, 0, 1, 14, 1);
        cyc(1, 14, 14, 1, 1, 1, 15, 0, 0, 1);
        iss(14, 14, 15, 0);
        repeat (4) bub();
        // halt for 5 cycles during a stall
        cyc(1, 1, 0, 1, 0, 1, 16, 1);
        repeat (5) cyc(1, 16, 16, 1, 1, 1, 17, 0, 1, 0);
        repeat (3) iss(16, 16, 17, 0);
        // reset mid-operation with two valid entries and a pending hazard
        iss(1, 1, 18, 0);
        iss(2, 2, 19, 1);
        cyc(1, 19, 18, 1, 1, 1, 20, 0, 0, 0, 0);
        iss(19, 18, 20, 0);
        // long run of stalls to saturate the narrow counters
        for (int i = 0; i < 20; i++) begin
            iss(1, 1, 21, 1);
            iss(21, 21, 22, 0);
        end
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 2) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
